// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM encoding, fixed vectors and redirect priority codes.
package cpu_defs;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [31:0] PC_RESET_VEC = 32'hBFC0_0000;
    localparam logic [31:0] PC_EXC_VEC   = 32'hBFC0_0380;

    // Larger code wins; a pending redirect is replaced by one of equal or higher code.
    localparam logic [1:0] PRIO_NONE = 2'd0;
    localparam logic [1:0] PRIO_BR   = 2'd1;
    localparam logic [1:0] PRIO_ERET = 2'd2;
    localparam logic [1:0] PRIO_EXC  = 2'd3;

endpackage

// File: rtl/pc_fetch_ctrl_redirect_sel.sv
// Combinational priority pick among exception, eret and branch redirect pulses.
module pc_redirect_sel
    import cpu_defs::*;
#(
    parameter logic [31:0] EXC_VEC = PC_EXC_VEC
) (
    input  logic        exc_i,
    input  logic        eret_i,
    input  logic        br_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] br_target_i,
    output logic        valid_o,
    output logic [31:0] target_o,
    output logic [1:0]  prio_o
);

    always_comb begin
        valid_o  = 1'b0;
        target_o = 32'h0;
        prio_o   = PRIO_NONE;
        if (exc_i) begin
            valid_o  = 1'b1;
            target_o = EXC_VEC;
            prio_o   = PRIO_EXC;
        end else if (eret_i) begin
            valid_o  = 1'b1;
            target_o = epc_i;
            prio_o   = PRIO_ERET;
        end else if (br_i) begin
            valid_o  = 1'b1;
            target_o = br_target_i;
            prio_o   = PRIO_BR;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: one outstanding SRAM-like request, holds the word for decode,
// queues redirects that arrive mid-request and discards the stale returned word.
module pc_fetch_ctrl
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET_VEC,
    parameter logic [31:0] EXC_VEC  = PC_EXC_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        exc_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [1:0]  state_o
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [1:0]  pend_prio_q, pend_prio_d;
    logic        kill_q, kill_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;

    logic        redir_v;
    logic [31:0] redir_tgt;
    logic [1:0]  redir_prio;
    logic        take_new;
    logic [31:0] eff_tgt;

    pc_redirect_sel #(.EXC_VEC(EXC_VEC)) u_redirect_sel (
        .exc_i       (exc_i),
        .eret_i      (eret_i),
        .br_i        (br_taken_i),
        .epc_i       (epc_i),
        .br_target_i (br_target_i),
        .valid_o     (redir_v),
        .target_o    (redir_tgt),
        .prio_o      (redir_prio)
    );

    // A live redirect replaces the queued one unless the queued one outranks it.
    assign take_new = redir_v && (!pend_v_q || (redir_prio >= pend_prio_q));
    assign eff_tgt  = take_new ? redir_tgt : pend_tgt_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_v_d    = pend_v_q;
        pend_tgt_d  = pend_tgt_q;
        pend_prio_d = pend_prio_q;
        kill_d      = kill_q;
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;

        if (take_new) begin
            pend_v_d    = 1'b1;
            pend_tgt_d  = redir_tgt;
            pend_prio_d = redir_prio;
        end

        case (state_q)
            S_REQ: begin
                // Once accepted, a request issued behind a queued redirect is stale.
                if (inst_addr_ok) begin
                    state_d = S_WAIT;
                    kill_d  = pend_v_q | redir_v;
                end
            end
            S_WAIT: begin
                if (redir_v) kill_d = 1'b1;
                if (inst_data_ok) begin
                    if (kill_q || redir_v) begin
                        kill_d      = 1'b0;
                        pc_d        = eff_tgt;
                        pend_v_d    = 1'b0;
                        pend_prio_d = PRIO_NONE;
                        state_d     = S_REQ;
                    end else begin
                        if_inst_d  = inst_rdata;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        state_d    = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (redir_v) begin
                    if_valid_d  = 1'b0;
                    pc_d        = eff_tgt;
                    pend_v_d    = 1'b0;
                    pend_prio_d = PRIO_NONE;
                    state_d     = S_REQ;
                end else if (!stall_i) begin
                    if_valid_d  = 1'b0;
                    pc_d        = pend_v_q ? pend_tgt_q : pc_q + 32'd4;
                    pend_v_d    = 1'b0;
                    pend_prio_d = PRIO_NONE;
                    state_d     = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            pend_v_q    <= 1'b0;
            pend_tgt_q  <= 32'h0;
            pend_prio_q <= PRIO_NONE;
            kill_q      <= 1'b0;
            if_valid_q  <= 1'b0;
            if_pc_q     <= 32'h0;
            if_inst_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_v_q    <= pend_v_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_prio_q <= pend_prio_d;
            kill_q      <= kill_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
        end
    end

    // Request handshake: inst_req/inst_addr hold steady until inst_addr_ok; inst_data_ok
    // completes the single outstanding request.
    assign inst_req  = (state_q == S_REQ) && !rst;
    assign inst_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Transaction-level bench: bench plays SRAM bridge and decode, predicts fetch addresses and words.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_PC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        exc = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = 32'h0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        addr_ok = 1'b0;
    logic        data_ok = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];

    // per-transaction plan: redirect events indexed by cycle slot before data return
    int          plan_ad, plan_dd, plan_st;
    bit          plan_out;
    bit          ev_v[16], ev_exc[16], ev_eret[16], ev_br[16];
    logic [31:0] ev_btgt[16], ev_epc[16];
    bit          out_exc, out_eret, out_br;
    logic [31:0] out_btgt, out_epc;

    bit          m_killed;
    int          m_prio;
    logic [31:0] m_tgt;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall),
        .br_taken_i   (br),
        .br_target_i  (br_target),
        .exc_i        (exc),
        .eret_i       (eret),
        .epc_i        (epc),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (addr_ok),
        .inst_data_ok (data_ok),
        .inst_rdata   (rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .state_o      (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic int ev_prio(input bit e, input bit er);
        return e ? 3 : (er ? 2 : 1);
    endfunction

    function automatic logic [31:0] ev_target(input bit e, input bit er, input logic [31:0] bt,
                                              input logic [31:0] ep);
        return e ? EXC_PC : (er ? ep : bt);
    endfunction

    task automatic rand_event(output bit e, output bit er, output bit b,
                              output logic [31:0] bt, output logic [31:0] ep);
        int r;
        r  = $urandom_range(1, 7);
        e  = r[2];
        er = r[1];
        b  = r[0];
        bt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
        ep = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        exc     = 1'b0;
        eret    = 1'b0;
        br      = 1'b0;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        stall   = 1'b0;
        rdata   = $urandom;
    endtask

    task automatic plan_clear(input int ad, input int dd, input int st);
        plan_ad  = ad;
        plan_dd  = dd;
        plan_st  = st;
        plan_out = 1'b0;
        for (int i = 0; i < 16; i++) ev_v[i] = 1'b0;
    endtask

    task automatic plan_event(input int s, input bit e, input bit er, input bit b,
                              input logic [31:0] bt, input logic [31:0] ep);
        ev_v[s]    = 1'b1;
        ev_exc[s]  = e;
        ev_eret[s] = er;
        ev_br[s]   = b;
        ev_btgt[s] = bt;
        ev_epc[s]  = ep;
    endtask

    task automatic plan_random();
        plan_clear($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        for (int s = 0; s < plan_ad + plan_dd + 2; s++) begin
            if ($urandom_range(0, 5) == 0) begin
                rand_event(ev_exc[s], ev_eret[s], ev_br[s], ev_btgt[s], ev_epc[s]);
                ev_v[s] = 1'b1;
            end
        end
        plan_out = ($urandom_range(0, 3) == 0);
        rand_event(out_exc, out_eret, out_br, out_btgt, out_epc);
    endtask

    // Drive the planned pulses for this slot and fold them into the queued-redirect model.
    task automatic apply_slot(input int s);
        int p;
        if (ev_v[s]) begin
            exc       = ev_exc[s];
            eret      = ev_eret[s];
            br        = ev_br[s];
            br_target = ev_btgt[s];
            epc       = ev_epc[s];
            p = ev_prio(ev_exc[s], ev_eret[s]);
            if (!m_killed || p >= m_prio) begin
                m_prio = p;
                m_tgt  = ev_target(ev_exc[s], ev_eret[s], ev_btgt[s], ev_epc[s]);
            end
            m_killed = 1'b1;
        end
    endtask

    task automatic run_txn();
        int          slot;
        logic [31:0] a;
        slot     = 0;
        m_killed = 1'b0;
        m_prio   = 0;
        m_tgt    = 32'h0;
        check("sb_depth", exp_q.size(), 1);
        a = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;

        for (int i = 0; i < plan_ad; i++) begin
            check("req_hold", {31'b0, inst_req}, 1);
            check("addr_hold", inst_addr, a);
            data_ok = $urandom_range(0, 1);
            apply_slot(slot++);
            step();
        end
        check("req_on", {31'b0, inst_req}, 1);
        check("req_addr", inst_addr, a);
        addr_ok = 1'b1;
        apply_slot(slot++);
        step();

        for (int i = 0; i < plan_dd; i++) begin
            check("wait_noreq", {31'b0, inst_req}, 0);
            check("wait_novalid", {31'b0, if_valid}, 0);
            apply_slot(slot++);
            step();
        end
        check("data_noreq", {31'b0, inst_req}, 0);
        data_ok = 1'b1;
        rdata   = mem_word(a);
        apply_slot(slot++);
        step();

        if (m_killed) begin
            check("kill_novalid", {31'b0, if_valid}, 0);
            check("kill_req", {31'b0, inst_req}, 1);
            exp_q.push_back(m_tgt);
            return;
        end

        for (int i = 0; i <= plan_st; i++) begin
            check("out_valid", {31'b0, if_valid}, 1);
            check("out_pc", if_pc, a);
            check("out_inst", if_inst, mem_word(a));
            check("out_noreq", {31'b0, inst_req}, 0);
            if (i < plan_st) begin
                stall   = 1'b1;
                data_ok = $urandom_range(0, 1);
                step();
            end
        end
        if (plan_out) begin
            stall     = 1'b1;
            exc       = out_exc;
            eret      = out_eret;
            br        = out_br;
            br_target = out_btgt;
            epc       = out_epc;
            step();
            exp_q.push_back(ev_target(out_exc, out_eret, out_btgt, out_epc));
        end else begin
            step();
            exp_q.push_back(a + 32'd4);
        end
        check("after_novalid", {31'b0, if_valid}, 0);
        check("after_req", {31'b0, inst_req}, 1);
    endtask

    task automatic reset_in_wait();
        logic [31:0] a;
        a = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
        check("rw_addr", inst_addr, a);
        addr_ok = 1'b1;
        step();
        check("rw_noreq", {31'b0, inst_req}, 0);
        rst = 1'b1;
        #1;
        check("rw_req_clr", {31'b0, inst_req}, 0);
        check("rw_valid_clr", {31'b0, if_valid}, 0);
        check("rw_pc_clr", if_pc, 32'h0);
        check("rw_inst_clr", if_inst, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        exp_q.delete();
        exp_q.push_back(RST_PC);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_req", {31'b0, inst_req}, 0);
        check("rst_valid", {31'b0, if_valid}, 0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_inst", if_inst, 32'h0);
        rst = 1'b0;
        step();
        exp_q.push_back(RST_PC);

        // sequential fetch, stall hold, branch in wait
        for (int i = 0; i < 3; i++) begin
            plan_clear(0, 0, 0);
            run_txn();
        end
        plan_clear(0, 0, 5);
        run_txn();
        plan_clear(0, 1, 0);
        plan_event(1, 1'b0, 1'b0, 1'b1, 32'hBFC0_0100, 32'h0);
        run_txn();

        // exc beats br; eret while holding a word
        plan_clear(0, 1, 0);
        plan_event(1, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0);
        run_txn();
        plan_clear(0, 0, 1);
        plan_out = 1'b1;
        out_exc = 1'b0; out_eret = 1'b1; out_br = 1'b0;
        out_btgt = 32'h0; out_epc = 32'hBFC0_0020;
        run_txn();
        plan_clear(0, 0, 0);
        run_txn();

        // redirect while addr_ok held low; lower priority does not overwrite
        plan_clear(4, 0, 0);
        plan_event(1, 1'b0, 1'b0, 1'b1, 32'hBFC0_0200, 32'h0);
        run_txn();
        plan_clear(2, 1, 0);
        plan_event(0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0040);
        plan_event(2, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0);
        run_txn();
        plan_clear(0, 0, 0);
        run_txn();

        // reset mid-request, then PC wrap
        reset_in_wait();
        plan_clear(0, 0, 0);
        run_txn();
        plan_clear(0, 0, 0);
        plan_event(0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
        run_txn();
        for (int i = 0; i < 2; i++) begin
            plan_clear(0, 0, 0);
            run_txn();
        end

        for (int i = 0; i < 120; i++) begin
            plan_random();
            run_txn();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
